// File: rtl/truth_table_sweeper.sv
`timescale 1ns/1ps
// truth_table_sweeper
// Clocked self-checking sweep around a 4-input / 3-output minterm block.
// Drives codes 0..15 on {w,x,y,z}. For each code it waits SETTLE_CYCLES,
// samples {r2,r1,r0} into a 16-entry table and compares the sample with the
// expected truth tables. It counts mismatching codes and remembers the first
// failing code.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_R0        = 16'hFAC8,
  parameter logic [15:0] EXP_R1        = 16'hF0E0,
  parameter logic [15:0] EXP_R2        = 16'hE880
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic       r0,
  input  logic       r1,
  input  logic       r2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] mismatch_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_idx,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  // Expected {r2,r1,r0} for one code, taken from the three truth-table words.
  function automatic logic [2:0] expected_result(input logic [3:0] code);
    return {EXP_R2[code], EXP_R1[code], EXP_R0[code]};
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  settle_cnt_r, settle_cnt_s;
  logic [4:0]  mismatch_cnt_r, mismatch_cnt_s;
  logic        fail_valid_r, fail_valid_s;
  logic [3:0]  fail_idx_r, fail_idx_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        pass_r, pass_s;
  logic        wr_en_s;
  logic [2:0]  sample_s;
  logic [2:0]  table_r [16];

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    settle_cnt_s   = settle_cnt_r;
    mismatch_cnt_s = mismatch_cnt_r;
    fail_valid_s   = fail_valid_r;
    fail_idx_s     = fail_idx_r;
    busy_s         = busy_r;
    done_s         = done_r;
    pass_s         = pass_r;
    wr_en_s        = 1'b0;
    sample_s       = {r2, r1, r0};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s        = ST_DRIVE;
          idx_s          = 4'd0;
          mismatch_cnt_s = 5'd0;
          fail_valid_s   = 1'b0;
          busy_s         = 1'b1;
          done_s         = 1'b0;
          pass_s         = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_DRIVE: begin
        settle_cnt_s = SETTLE_LOAD;
        state_s      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_r <= 4'd1) begin
          state_s = ST_SAMPLE;
        end else begin
          settle_cnt_s = settle_cnt_r - 4'd1;
        end
      end
      ST_SAMPLE: begin
        wr_en_s = 1'b1;
        if (sample_s != expected_result(idx_r)) begin
          // At most 16 increments per sweep, so the 5-bit count never wraps.
          mismatch_cnt_s = mismatch_cnt_r + 5'd1;
          if (!fail_valid_r) begin
            fail_valid_s = 1'b1;
            fail_idx_s   = idx_r;
          end else begin
            fail_idx_s = fail_idx_r;
          end
        end else begin
          mismatch_cnt_s = mismatch_cnt_r;
        end
        if (idx_r == 4'd15) begin
          // idx stays at 15, so w..z show 4'b1111 while the FSM is in DONE.
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (mismatch_cnt_s == 5'd0);
        end else begin
          idx_s   = idx_r + 4'd1;
          state_s = ST_DRIVE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // Control and status registers; reset returns everything to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= 4'd0;
      settle_cnt_r   <= 4'd0;
      mismatch_cnt_r <= 5'd0;
      fail_valid_r   <= 1'b0;
      fail_idx_r     <= 4'd0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      settle_cnt_r   <= settle_cnt_s;
      mismatch_cnt_r <= mismatch_cnt_s;
      fail_valid_r   <= fail_valid_s;
      fail_idx_r     <= fail_idx_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      pass_r         <= pass_s;
    end
  end

  // Result table: cleared by reset, one entry written per SAMPLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        table_r[i] <= 3'b000;
      end
    end else if (wr_en_s) begin
      table_r[idx_r] <= sample_s;
    end else begin
      table_r[idx_r] <= table_r[idx_r];
    end
  end

  assign w            = idx_r[3];
  assign x            = idx_r[2];
  assign y            = idx_r[1];
  assign z            = idx_r[0];
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign mismatch_cnt = mismatch_cnt_r;
  assign fail_valid   = fail_valid_r;
  assign fail_idx     = fail_idx_r;
  assign rd_data      = table_r[rd_addr];

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential test harness stage wrapped around the 4-input/3-output combinational minterm block.
- Upstream side: drives w,x,y,z through codes 0..15.
- Downstream side: samples r0,r1,r2 after a settle delay and stores each result in a 16-entry table.
- Compares each result against expected truth tables, counts mismatches and reports pass/fail, replacing the delay-based display loop with a clocked, self-checking sweep.

Parameters:
- SETTLE_CYCLES, 2, cycles w..z are held stable before sampling r0..r2; legal range 1..15.
- EXP_R0, 16'hFAC8, expected r0; bit i = value at code i.
- EXP_R1, 16'hF0E0, expected r1; bit i = value at code i.
- EXP_R2, 16'hE880, expected r2; bit i = value at code i.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  sweep request, sampled in IDLE and DONE only.
- w  output  1  code bit 3 to the minterm block.
- x  output  1  code bit 2.
- y  output  1  code bit 1.
- z  output  1  code bit 0.
- r0  input  1  result 0 from the minterm block.
- r1  input  1  result 1.
- r2  input  1  result 2.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; level, held in DONE.
- pass  output  1  done and zero mismatches.
- mismatch_cnt  output  5  mismatching codes, 0..16.
- fail_valid  output  1  at least one mismatch seen this sweep.
- fail_idx  output  4  first mismatching code.
- rd_addr  input  4  table readback address.
- rd_data  output  3  {r2,r1,r0} stored at rd_addr; combinational read.

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low: FSM to IDLE immediately. w,x,y,z, busy, done, pass, fail_valid = 0; mismatch_cnt = 0; fail_idx = 0; idx = 0; all 16 table entries = 3'b000. Applies at any time, including mid-sweep; no partial results retained.
- w..z are registered outputs and always equal {w,x,y,z} = idx. Single clock domain; r0..r2 are used unsynchronised.
- State IDLE: start=1 → DRIVE. Clears idx, mismatch_cnt and fail_valid; sets busy=1 on the next edge.
- State DRIVE (1 cycle): w..z = idx; load settle counter with SETTLE_CYCLES → SETTLE.
- State SETTLE (SETTLE_CYCLES cycles): counter decrements; reaching 1 → SAMPLE.
- State SAMPLE (1 cycle):
  - table[idx] ← {r2,r1,r0}.
  - If {r2,r1,r0} != {EXP_R2[idx],EXP_R1[idx],EXP_R0[idx]}: mismatch_cnt += 1; if fail_valid=0, set fail_idx=idx and fail_valid=1.
  - idx=15 → DONE; otherwise idx += 1 → DRIVE.
- State DONE: busy=0, done=1, pass = (mismatch_cnt==0). w..z hold 4'b1111. start=1 → DRIVE with the same clears as IDLE; done and pass drop on that edge.
- start while busy: ignored, with no effect on state or counters.
- Sweep length: exactly 16*(SETTLE_CYCLES+2) cycles from the edge accepting start to the edge asserting done. SETTLE_CYCLES=2 gives 64.
- mismatch_cnt saturates naturally at 16; 5 bits, no wrap.
- idx wrap: idx is never incremented past 15.
- rd_data is valid in every state. During a sweep, unsampled entries show the previous sweep's values (or 0 after reset).

Test Plan:
1. Bench models r0..r2 with the minterm equations, SETTLE_CYCLES=2, start pulse → busy=1 next cycle; done=1 exactly 64 cycles after acceptance; pass=1, mismatch_cnt=0, fail_valid=0. rd_addr=13 → 3'b111; rd_addr=10 → 3'b000; rd_addr=11 → 3'b101.
2. Bench forces r1 stuck-at-0 → mismatch_cnt=7, fail_valid=1, fail_idx=5, pass=0, done=1. rd_addr=6 → 3'b001.
3. Monitor w..z during a sweep → codes 0,1,...,15 in order, each held SETTLE_CYCLES+2 cycles. Sampled r matches the code held at that moment.
4. start pulsed at cycle 20 of a sweep → no change, done still at cycle 64. start in DONE with faulty model → done drops, counters restart from 0, new result reported at +64.
5. rst_n low for 1 ns while idx=7 (async, between edges) → all outputs 0 immediately, state IDLE, rd_data=0 at all 16 addresses. Next start gives a full 64-cycle sweep with pass=1.
6. SETTLE_CYCLES=1 with correct model → done 48 cycles after start; pass=1; table matches scenario 1.
